// File: rtl/cpu7_csr_acc.sv
// CSR access sequencer: read old value, optionally write, then write the old value back to rd.
// Fixed 3-cycle latency from acceptance to writeback; csr_ecl_busy stalls ecl for the whole operation.
module cpu7_csr_acc #(
   parameter int GRLEN   = 32,
   parameter int CSR_BIT = 14
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               ecl_csr_req_e,
   input  logic [1:0]         ecl_csr_op_e,
   input  logic [CSR_BIT-1:0] ecl_csr_num_e,
   input  logic [4:0]         ecl_csr_rd_e,
   input  logic [GRLEN-1:0]   ecl_csr_rdval_e,
   input  logic [GRLEN-1:0]   ecl_csr_rjval_e,
   input  logic               ecl_csr_flush,
   input  logic [GRLEN-1:0]   csr_rdata,
   output logic [CSR_BIT-1:0] csr_raddr,
   output logic [CSR_BIT-1:0] csr_waddr,
   output logic [GRLEN-1:0]   csr_wdata,
   output logic [GRLEN-1:0]   csr_mask,
   output logic               csr_wen,
   output logic               csr_ecl_busy,
   output logic               csr_ecl_ill,
   output logic               csr_wb_valid,
   output logic [4:0]         csr_wb_rd,
   output logic [GRLEN-1:0]   csr_wb_data
);

   typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;

   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_XCHG = 2'b10;
   localparam logic [1:0] OP_ILL  = 2'b11;

   state_t               state_q;
   logic [1:0]           op_q;
   logic [CSR_BIT-1:0]   num_q;
   logic [4:0]           rd_q;
   logic [GRLEN-1:0]     rdval_q;
   logic [GRLEN-1:0]     rjval_q;
   logic [GRLEN-1:0]     old_q;
   logic [CSR_BIT-1:0]   raddr_q;
   logic [CSR_BIT-1:0]   waddr_q;
   logic [GRLEN-1:0]     wdata_q;
   logic [GRLEN-1:0]     mask_q;
   logic                 wen_q;
   logic                 busy_q;
   logic                 ill_q;
   logic                 wb_valid_q;
   logic [4:0]           wb_rd_q;
   logic [GRLEN-1:0]     wb_data_q;
   logic                 accept;

   assign accept = (state_q == IDLE) && ecl_csr_req_e && !ecl_csr_flush;

   // Outputs are registered and default to zero, so each pulse lasts exactly one state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         op_q       <= '0;
         num_q      <= '0;
         rd_q       <= '0;
         rdval_q    <= '0;
         rjval_q    <= '0;
         old_q      <= '0;
         raddr_q    <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         mask_q     <= '0;
         wen_q      <= 1'b0;
         busy_q     <= 1'b0;
         ill_q      <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         raddr_q    <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         mask_q     <= '0;
         wen_q      <= 1'b0;
         busy_q     <= 1'b0;
         ill_q      <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q    <= ecl_csr_op_e;
                  num_q   <= ecl_csr_num_e;
                  rd_q    <= ecl_csr_rd_e;
                  rdval_q <= ecl_csr_rdval_e;
                  rjval_q <= ecl_csr_rjval_e;
                  if (ecl_csr_op_e == OP_ILL) begin
                     ill_q <= 1'b1;
                  end else begin
                     state_q <= RD;
                     raddr_q <= ecl_csr_num_e;
                     busy_q  <= 1'b1;
                  end
               end
            end
            RD: begin
               if (ecl_csr_flush) begin
                  state_q <= IDLE;
               end else begin
                  // Old value is sampled here, before the write, so xchg sees pre-write contents.
                  old_q   <= csr_rdata;
                  state_q <= WR;
                  busy_q  <= 1'b1;
                  if (op_q == OP_WR || op_q == OP_XCHG) begin
                     wen_q   <= 1'b1;
                     waddr_q <= num_q;
                     wdata_q <= rdval_q;
                     mask_q  <= (op_q == OP_XCHG) ? rjval_q : {GRLEN{1'b1}};
                  end
               end
            end
            WR: begin
               state_q    <= WB;
               busy_q     <= 1'b1;
               wb_valid_q <= (rd_q != 5'd0);
               wb_rd_q    <= rd_q;
               wb_data_q  <= old_q;
            end
            WB: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign csr_raddr    = raddr_q;
   assign csr_waddr    = waddr_q;
   assign csr_wdata    = wdata_q;
   assign csr_mask     = mask_q;
   assign csr_wen      = wen_q;
   assign csr_ecl_busy = busy_q;
   assign csr_ecl_ill  = ill_q;
   assign csr_wb_valid = wb_valid_q;
   assign csr_wb_rd    = wb_rd_q;
   assign csr_wb_data  = wb_data_q;

endmodule

// File: tb/tb_cpu7_csr_acc.sv
// Bench for cpu7_csr_acc: scoreboard of expected CSR writes and writebacks plus per-scenario cycle checks.
module tb_cpu7_csr_acc;

   logic        clk;
   logic        resetn;
   logic        req;
   logic [1:0]  op;
   logic [13:0] num;
   logic [4:0]  rd;
   logic [31:0] rdval;
   logic [31:0] rjval;
   logic        flush;
   logic [31:0] csr_rdata;
   logic [13:0] raddr;
   logic [13:0] waddr;
   logic [31:0] wdata;
   logic [31:0] mask;
   logic        wen;
   logic        busy;
   logic        ill;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   logic [31:0] csr_mem [0:16383];

   typedef struct packed {
      logic [13:0] addr;
      logic [31:0] data;
      logic [31:0] mask;
   } wr_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   wr_t exp_wr_q[$];
   wb_t exp_wb_q[$];
   wr_t ew;
   wb_t eb;

   int errors  = 0;
   int checks  = 0;
   int wen_cnt = 0;
   int wb_cnt  = 0;
   int ill_cnt = 0;

   cpu7_csr_acc #(.GRLEN(32), .CSR_BIT(14)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .ecl_csr_req_e   (req),
      .ecl_csr_op_e    (op),
      .ecl_csr_num_e   (num),
      .ecl_csr_rd_e    (rd),
      .ecl_csr_rdval_e (rdval),
      .ecl_csr_rjval_e (rjval),
      .ecl_csr_flush   (flush),
      .csr_rdata       (csr_rdata),
      .csr_raddr       (raddr),
      .csr_waddr       (waddr),
      .csr_wdata       (wdata),
      .csr_mask        (mask),
      .csr_wen         (wen),
      .csr_ecl_busy    (busy),
      .csr_ecl_ill     (ill),
      .csr_wb_valid    (wb_valid),
      .csr_wb_rd       (wb_rd),
      .csr_wb_data     (wb_data)
   );

   assign csr_rdata = csr_mem[raddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every write strobe and writeback must match the oldest pending expectation.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (wen === 1'b1) begin
            wen_cnt++;
            checks++;
            if (exp_wr_q.size() == 0) begin
               errors++;
               $display("FAIL sb_wr_unexpected: got addr=%0h data=%0h mask=%0h expected no write", waddr, wdata, mask);
            end else begin
               ew = exp_wr_q.pop_front();
               if ({waddr, wdata, mask} !== ew) begin
                  errors++;
                  $display("FAIL sb_wr: got %0h/%0h/%0h expected %0h/%0h/%0h", waddr, wdata, mask, ew.addr, ew.data, ew.mask);
               end
            end
         end
         if (wb_valid === 1'b1) begin
            wb_cnt++;
            checks++;
            if (exp_wb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_wb_unexpected: got rd=%0d data=%0h expected no writeback", wb_rd, wb_data);
            end else begin
               eb = exp_wb_q.pop_front();
               if ({wb_rd, wb_data} !== eb) begin
                  errors++;
                  $display("FAIL sb_wb: got rd=%0d data=%0h expected rd=%0d data=%0h", wb_rd, wb_data, eb.rd, eb.data);
               end
            end
         end
         if (ill === 1'b1) ill_cnt++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [1:0] o, input logic [13:0] n, input logic [4:0] r,
                            input logic [31:0] dv, input logic [31:0] jv);
      req = 1'b1; op = o; num = n; rd = r; rdval = dv; rjval = jv;
   endtask

   task automatic push_wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
      wr_t t;
      t.addr = a; t.data = d; t.mask = m;
      exp_wr_q.push_back(t);
   endtask

   task automatic push_wb(input logic [4:0] r, input logic [31:0] d);
      wb_t t;
      t.rd = r; t.data = d;
      exp_wb_q.push_back(t);
   endtask

   task automatic test_reset();
      req = 1'b0; op = '0; num = '0; rd = '0; rdval = '0; rjval = '0; flush = 1'b0;
      resetn = 1'b1;
      #2 resetn = 1'b0;
      drive_req(2'b01, 14'd5, 5'd7, 32'h0000_FFFF, 32'h1);
      tick(); tick();
      checks++;
      if ({raddr, waddr, wdata, mask, wb_rd, wb_data} !== '0) begin
         errors++;
         $display("FAIL reset_data: got %0h/%0h/%0h/%0h/%0h/%0h expected all 0", raddr, waddr, wdata, mask, wb_rd, wb_data);
      end
      checks++;
      if ({busy, wen, ill, wb_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctl: got %b expected 0000", {busy, wen, ill, wb_valid});
      end
      // First acceptance on the first rising edge after release.
      csr_mem[1] = 32'h0000_00A5;
      drive_req(2'b00, 14'd1, 5'd3, 32'h0, 32'h0);
      push_wb(5'd3, 32'h0000_00A5);
      resetn = 1'b1;
      tick();
      req = 1'b0;
      checks++;
      if ({busy, raddr} !== {1'b1, 14'd1}) begin
         errors++;
         $display("FAIL first_accept: got busy=%b raddr=%0h expected busy=1 raddr=1", busy, raddr);
      end
      tick(); tick(); tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL first_done: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_csrrd();
      logic [2:0] e;
      csr_mem[0] = 32'h7;
      drive_req(2'b00, 14'd0, 5'd5, 32'hDEAD_BEEF, 32'h0);
      push_wb(5'd5, 32'h7);
      tick();
      req = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         e = {(k <= 3), 1'b0, (k == 3)};
         checks++;
         if ({busy, wen, wb_valid} !== e) begin
            errors++;
            $display("FAIL csrrd_cyc%0d: got busy/wen/wbv=%b expected %b", k, {busy, wen, wb_valid}, e);
         end
         tick();
      end
   endtask

   task automatic test_csrxchg();
      csr_mem[12] = 32'h1234_5678;
      drive_req(2'b10, 14'hC, 5'd9, 32'hFFFF_0000, 32'h0000_FF00);
      push_wr(14'hC, 32'hFFFF_0000, 32'h0000_FF00);
      push_wb(5'd9, 32'h1234_5678);
      tick();
      req = 1'b0;
      checks++;
      if (raddr !== 14'hC) begin
         errors++;
         $display("FAIL xchg_raddr: got %0h expected c", raddr);
      end
      tick();
      checks++;
      if ({wen, waddr, wdata, mask} !== {1'b1, 14'hC, 32'hFFFF_0000, 32'h0000_FF00}) begin
         errors++;
         $display("FAIL xchg_wr: got wen=%b addr=%0h data=%0h mask=%0h expected 1/c/ffff0000/ff00", wen, waddr, wdata, mask);
      end
      tick();
      checks++;
      if ({wb_valid, wb_data, wen, waddr, raddr} !== {1'b1, 32'h1234_5678, 1'b0, 14'h0, 14'h0}) begin
         errors++;
         $display("FAIL xchg_wb: got wbv=%b data=%0h wen=%b waddr=%0h raddr=%0h expected 1/12345678/0/0/0", wb_valid, wb_data, wen, waddr, raddr);
      end
      tick();
      checks++;
      if ({busy, wb_rd, wb_data} !== '0) begin
         errors++;
         $display("FAIL xchg_idle: got busy=%b rd=%0d data=%0h expected 0", busy, wb_rd, wb_data);
      end
   endtask

   task automatic test_flush();
      int w0;
      int b0;
      w0 = wen_cnt; b0 = wb_cnt;
      flush = 1'b1;
      drive_req(2'b01, 14'd3, 5'd4, 32'h0BAD_0BAD, 32'h0);
      tick();
      checks++;
      if ({busy, raddr} !== {1'b0, 14'd0}) begin
         errors++;
         $display("FAIL flush_idle: got busy=%b raddr=%0h expected 0/0", busy, raddr);
      end
      flush = 1'b0;
      tick();
      req = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if ({busy, wen} !== 2'b00) begin
         errors++;
         $display("FAIL flush_rd: got busy/wen=%b expected 00", {busy, wen});
      end
      tick(); tick();
      checks++;
      if ((wen_cnt - w0) !== 0 || (wb_cnt - b0) !== 0) begin
         errors++;
         $display("FAIL flush_rd_counts: got wen=%0d wb=%0d expected 0/0", wen_cnt - w0, wb_cnt - b0);
      end
      // Flush during WR and WB must not disturb completion.
      csr_mem[6] = 32'h55;
      drive_req(2'b01, 14'd6, 5'd8, 32'h0000_CAFE, 32'h0);
      push_wr(14'd6, 32'h0000_CAFE, 32'hFFFF_FFFF);
      push_wb(5'd8, 32'h55);
      tick();
      req = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      checks++;
      if ({busy, wb_valid} !== 2'b11) begin
         errors++;
         $display("FAIL flush_wr_ignored: got busy/wbv=%b expected 11", {busy, wb_valid});
      end
      tick();
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_wb_done: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] bh;
      logic [9:0] wh;
      logic [9:0] vh;
      csr_mem[9] = 32'h99;
      drive_req(2'b01, 14'd9, 5'd10, 32'h1111_2222, 32'h0);
      push_wr(14'd9, 32'h1111_2222, 32'hFFFF_FFFF);
      push_wr(14'd9, 32'h1111_2222, 32'hFFFF_FFFF);
      push_wb(5'd10, 32'h99);
      push_wb(5'd10, 32'h99);
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 5) req = 1'b0;
         bh[c-1] = busy;
         wh[c-1] = wen;
         vh[c-1] = wb_valid;
      end
      checks++;
      if (bh !== 10'b0001110111) begin
         errors++;
         $display("FAIL b2b_busy: got %b expected 0001110111", bh);
      end
      checks++;
      if (wh !== 10'b0000100010) begin
         errors++;
         $display("FAIL b2b_wen: got %b expected 0000100010", wh);
      end
      checks++;
      if (vh !== 10'b0001000100) begin
         errors++;
         $display("FAIL b2b_wbv: got %b expected 0001000100", vh);
      end
   endtask

   task automatic test_illegal();
      int i0;
      int w0;
      int b0;
      logic [3:0] bh;
      logic [3:0] vh;
      i0 = ill_cnt; w0 = wen_cnt;
      drive_req(2'b11, 14'd2, 5'd6, 32'h1, 32'h2);
      tick();
      req = 1'b0;
      checks++;
      if ({ill, busy} !== 2'b10) begin
         errors++;
         $display("FAIL ill_pulse: got ill/busy=%b expected 10", {ill, busy});
      end
      tick();
      checks++;
      if (ill !== 1'b0) begin
         errors++;
         $display("FAIL ill_single: got ill=%b expected 0", ill);
      end
      tick();
      checks++;
      if ((ill_cnt - i0) !== 1 || (wen_cnt - w0) !== 0) begin
         errors++;
         $display("FAIL ill_counts: got ill=%0d wen=%0d expected 1/0", ill_cnt - i0, wen_cnt - w0);
      end
      b0 = wb_cnt;
      csr_mem[4] = 32'h4444;
      drive_req(2'b00, 14'd4, 5'd0, 32'h0, 32'h0);
      tick();
      req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bh[k] = busy;
         vh[k] = wb_valid;
         tick();
      end
      checks++;
      if ({bh, vh} !== {4'b0111, 4'b0000}) begin
         errors++;
         $display("FAIL rd0: got busy=%b wbv=%b expected 0111/0000", bh, vh);
      end
      checks++;
      if ((wb_cnt - b0) !== 0) begin
         errors++;
         $display("FAIL rd0_count: got %0d expected 0", wb_cnt - b0);
      end
   endtask

   task automatic test_reset_wr();
      drive_req(2'b01, 14'd5, 5'd7, 32'h0000_ABCD, 32'h0);
      tick();
      req = 1'b0;
      tick();
      checks++;
      if (wen !== 1'b1) begin
         errors++;
         $display("FAIL rst_wr_pre: got wen=%b expected 1", wen);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if ({wen, busy, ill, wb_valid, raddr, waddr, wdata, mask, wb_rd, wb_data} !== '0) begin
         errors++;
         $display("FAIL rst_wr_outs: got wen=%b busy=%b waddr=%0h wdata=%0h mask=%0h expected all 0", wen, busy, waddr, wdata, mask);
      end
      @(posedge clk);
      #1;
      resetn = 1'b1;
      tick();
      checks++;
      if ({busy, wen} !== 2'b00) begin
         errors++;
         $display("FAIL rst_release_idle: got busy/wen=%b expected 00", {busy, wen});
      end
      csr_mem[2] = 32'h22;
      drive_req(2'b00, 14'd2, 5'd2, 32'h0, 32'h0);
      push_wb(5'd2, 32'h22);
      tick();
      req = 1'b0;
      checks++;
      if ({busy, raddr} !== {1'b1, 14'd2}) begin
         errors++;
         $display("FAIL rst_reaccept: got busy=%b raddr=%0h expected 1/2", busy, raddr);
      end
      tick(); tick(); tick();
   endtask

   initial begin
      test_reset();
      test_csrrd();
      test_csrxchg();
      test_flush();
      test_back_to_back();
      test_illegal();
      test_reset_wr();
      checks++;
      if (exp_wr_q.size() !== 0) begin
         errors++;
         $display("FAIL sb_wr_drain: got %0d pending expected 0", exp_wr_q.size());
      end
      checks++;
      if (exp_wb_q.size() !== 0) begin
         errors++;
         $display("FAIL sb_wb_drain: got %0d pending expected 0", exp_wb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
